// File: rtl/alu_pkg.sv
// Opcode encoding and reset constant shared by the MIPS ALU and its muldiv unit.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package alu_pkg;

    localparam logic [5:0] ALU_ADD   = 6'd0;
    localparam logic [5:0] ALU_ADDU  = 6'd1;
    localparam logic [5:0] ALU_SUB   = 6'd2;
    localparam logic [5:0] ALU_SUBU  = 6'd3;
    localparam logic [5:0] ALU_AND   = 6'd4;
    localparam logic [5:0] ALU_OR    = 6'd5;
    localparam logic [5:0] ALU_XOR   = 6'd6;
    localparam logic [5:0] ALU_NOR   = 6'd7;
    localparam logic [5:0] ALU_SLT   = 6'd8;
    localparam logic [5:0] ALU_SLTU  = 6'd9;
    localparam logic [5:0] ALU_SLL   = 6'd10;
    localparam logic [5:0] ALU_SRL   = 6'd11;
    localparam logic [5:0] ALU_SRA   = 6'd12;
    localparam logic [5:0] ALU_SLLV  = 6'd13;
    localparam logic [5:0] ALU_SRLV  = 6'd14;
    localparam logic [5:0] ALU_SRAV  = 6'd15;
    localparam logic [5:0] ALU_LUI   = 6'd16;
    localparam logic [5:0] ALU_MULT  = 6'd17;
    localparam logic [5:0] ALU_MULTU = 6'd18;
    localparam logic [5:0] ALU_DIV   = 6'd19;
    localparam logic [5:0] ALU_DIVU  = 6'd20;
    localparam logic [5:0] ALU_MFHI  = 6'd21;
    localparam logic [5:0] ALU_MFLO  = 6'd22;
    localparam logic [5:0] ALU_MTHI  = 6'd23;
    localparam logic [5:0] ALU_MTLO  = 6'd24;
    localparam logic [5:0] ALU_PASSA = 6'd25;
    localparam logic [5:0] ALU_PASSB = 6'd26;

    localparam logic [31:0] ALU_RST_VAL = 32'h0;

endpackage

// File: rtl/mips_alu_muldiv.sv
// Combinational 32x32 multiply/divide, signed or unsigned; returns {hi,lo}.
// Latency: 0 (purely combinational, registered by the parent).
// Backpressure: none.
module mips_alu_muldiv
    import alu_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        is_signed_i,
    input  logic        is_div_i,
    output logic [63:0] hilo_o
);

    logic [63:0] a_ext;
    logic [63:0] b_ext;
    logic [63:0] product;

    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] b_safe;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;

    // Sign- or zero-extend to 64 bits; the low 64 bits of the product are then correct for both forms.
    assign a_ext   = is_signed_i ? {{32{a_i[31]}}, a_i} : {32'h0, a_i};
    assign b_ext   = is_signed_i ? {{32{b_i[31]}}, b_i} : {32'h0, b_i};
    assign product = a_ext * b_ext;

    // Divide on magnitudes, then restore signs: quotient truncates toward zero, remainder follows A.
    assign a_neg  = is_signed_i & a_i[31];
    assign b_neg  = is_signed_i & b_i[31];
    assign a_mag  = a_neg ? (32'h0 - a_i) : a_i;
    assign b_mag  = b_neg ? (32'h0 - b_i) : b_i;
    assign b_safe = (b_mag == 32'h0) ? 32'h1 : b_mag;
    assign q_mag  = a_mag / b_safe;
    assign r_mag  = a_mag % b_safe;
    assign quot   = (a_neg ^ b_neg) ? (32'h0 - q_mag) : q_mag;
    assign rem    = a_neg ? (32'h0 - r_mag) : r_mag;

    // Select multiply or divide result and apply the divide special cases.
    always_comb begin
        hilo_o = product;
        if (is_div_i) begin
            if (b_i == 32'h0) begin
                hilo_o = {a_i, 32'hFFFF_FFFF};
            end else if (is_signed_i && (a_i == 32'h8000_0000) && (b_i == 32'hFFFF_FFFF)) begin
                hilo_o = {ALU_RST_VAL, 32'h8000_0000};
            end else begin
                hilo_o = {rem, quot};
            end
        end
    end

endmodule

// File: rtl/mips_alu.sv
// 32-bit MIPS integer ALU with next-HI/LO outputs. Optional macro: ALU_OVERFLOW_EN adds an overflow output.
// Latency: 1 CLK edge, one operation accepted every edge.
// Backpressure: none; no handshake, every edge consumes the inputs.
module mips_alu
    import alu_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [5:0]  ALU_control,
    input  logic [4:0]  shiftAmount,
    input  logic [31:0] HI_IN,
    input  logic [31:0] LO_IN,
    output logic [31:0] aluResult,
    output logic [31:0] HI_OUT,
    output logic [31:0] LO_OUT
`ifdef ALU_OVERFLOW_EN
    ,
    output logic        overflow
`endif
);

    logic [31:0] res_d, res_q;
    logic [31:0] hi_d,  hi_q;
    logic [31:0] lo_d,  lo_q;

    logic [31:0] sum;
    logic [31:0] diff;
    logic        slt;
    logic        sltu;
    logic [4:0]  shamt;
    logic        var_shift;
    logic        md_signed;
    logic        md_div;
    logic [63:0] md_hilo;

    assign sum  = A + B;
    assign diff = A - B;
    assign slt  = $signed(A) < $signed(B);
    assign sltu = A < B;

    // Variable shifts take their amount from A[4:0]; immediate shifts from shiftAmount.
    assign var_shift = (ALU_control == ALU_SLLV) || (ALU_control == ALU_SRLV) ||
                       (ALU_control == ALU_SRAV);
    assign shamt     = var_shift ? A[4:0] : shiftAmount;

    assign md_signed = (ALU_control == ALU_MULT) || (ALU_control == ALU_DIV);
    assign md_div    = (ALU_control == ALU_DIV)  || (ALU_control == ALU_DIVU);

    mips_alu_muldiv u_muldiv (
        .a_i         (A),
        .b_i         (B),
        .is_signed_i (md_signed),
        .is_div_i    (md_div),
        .hilo_o      (md_hilo)
    );

    // Next-state selection: HI/LO pass through unless the opcode writes them.
    always_comb begin
        res_d = ALU_RST_VAL;
        hi_d  = HI_IN;
        lo_d  = LO_IN;
        case (ALU_control)
            ALU_ADD, ALU_ADDU: res_d = sum;
            ALU_SUB, ALU_SUBU: res_d = diff;
            ALU_AND:           res_d = A & B;
            ALU_OR:            res_d = A | B;
            ALU_XOR:           res_d = A ^ B;
            ALU_NOR:           res_d = ~(A | B);
            ALU_SLT:           res_d = {31'h0, slt};
            ALU_SLTU:          res_d = {31'h0, sltu};
            ALU_SLL, ALU_SLLV: res_d = B << shamt;
            ALU_SRL, ALU_SRLV: res_d = B >> shamt;
            ALU_SRA, ALU_SRAV: res_d = $unsigned($signed(B) >>> shamt);
            ALU_LUI:           res_d = {B[15:0], 16'h0};
            ALU_MULT, ALU_MULTU, ALU_DIV, ALU_DIVU: begin
                hi_d = md_hilo[63:32];
                lo_d = md_hilo[31:0];
            end
            ALU_MFHI:          res_d = HI_IN;
            ALU_MFLO:          res_d = LO_IN;
            ALU_MTHI:          hi_d  = A;
            ALU_MTLO:          lo_d  = A;
            ALU_PASSA:         res_d = A;
            ALU_PASSB:         res_d = B;
            default:           res_d = ALU_RST_VAL;
        endcase
    end

    // Output registers; reset wins over any operation presented on the same edge.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            res_q <= ALU_RST_VAL;
            hi_q  <= ALU_RST_VAL;
            lo_q  <= ALU_RST_VAL;
        end else begin
            res_q <= res_d;
            hi_q  <= hi_d;
            lo_q  <= lo_d;
        end
    end

    assign aluResult = res_q;
    assign HI_OUT    = hi_q;
    assign LO_OUT    = lo_q;

`ifdef ALU_OVERFLOW_EN
    logic ov_d, ov_q;

    // Signed overflow only for the trapping forms ADD and SUB; results still wrap.
    always_comb begin
        ov_d = 1'b0;
        if (ALU_control == ALU_ADD) begin
            ov_d = (A[31] == B[31]) && (sum[31] != A[31]);
        end else if (ALU_control == ALU_SUB) begin
            ov_d = (A[31] != B[31]) && (diff[31] != A[31]);
        end
    end

    // Overflow flag register, aligned with aluResult.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            ov_q <= 1'b0;
        end else begin
            ov_q <= ov_d;
        end
    end

    assign overflow = ov_q;
`endif

endmodule

// File: tb/tb_mips_alu.sv
// Self-checking bench for mips_alu: directed literal cases plus randomized ops against a behavioural model.
// Latency: checks outputs one edge after inputs are applied.
// Backpressure: none.
module tb_mips_alu;

    logic        CLK;
    logic        RESET;
    logic [31:0] A;
    logic [31:0] B;
    logic [5:0]  ALU_control;
    logic [4:0]  shiftAmount;
    logic [31:0] HI_IN;
    logic [31:0] LO_IN;
    logic [31:0] aluResult;
    logic [31:0] HI_OUT;
    logic [31:0] LO_OUT;
    logic        ov_act;

    int checks   = 0;
    int failures = 0;

    mips_alu dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .A           (A),
        .B           (B),
        .ALU_control (ALU_control),
        .shiftAmount (shiftAmount),
        .HI_IN       (HI_IN),
        .LO_IN       (LO_IN),
        .aluResult   (aluResult),
        .HI_OUT      (HI_OUT),
        .LO_OUT      (LO_OUT)
`ifdef ALU_OVERFLOW_EN
        ,
        .overflow    (ov_act)
`endif
    );

`ifndef ALU_OVERFLOW_EN
    assign ov_act = 1'b0;
`endif

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct packed {
        logic [31:0] res;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        ov;
    } exp_t;

    // Reference behaviour written from the opcode table with plain integer arithmetic.
    function automatic exp_t model(input int unsigned op, input logic [31:0] a, input logic [31:0] b,
                                   input logic [4:0] sh, input logic [31:0] hi, input logic [31:0] lo);
        exp_t e;
        int sa, sb;
        longint la, lb, s;
        longint unsigned ua, ub, up;
        sa = a;
        sb = b;
        la = sa;
        lb = sb;
        ua = a;
        ub = b;
        e.res = 32'h0;
        e.hi  = hi;
        e.lo  = lo;
        e.ov  = 1'b0;
        case (op)
            0, 1: begin
                e.res = a + b;
                s = la + lb;
                if (op == 0) e.ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            2, 3: begin
                e.res = a - b;
                s = la - lb;
                if (op == 2) e.ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4:  e.res = a & b;
            5:  e.res = a | b;
            6:  e.res = a ^ b;
            7:  e.res = ~(a | b);
            8:  e.res = (sa < sb) ? 32'd1 : 32'd0;
            9:  e.res = (a < b) ? 32'd1 : 32'd0;
            10: e.res = b << sh;
            11: e.res = b >> sh;
            12: e.res = sb >>> sh;
            13: e.res = b << a[4:0];
            14: e.res = b >> a[4:0];
            15: e.res = sb >>> a[4:0];
            16: e.res = b * 32'd65536;
            17: begin
                s = la * lb;
                e.hi = s[63:32];
                e.lo = s[31:0];
            end
            18: begin
                up = ua * ub;
                e.hi = up[63:32];
                e.lo = up[31:0];
            end
            19: begin
                if (b == 32'h0) begin
                    e.lo = 32'hFFFF_FFFF;
                    e.hi = a;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    e.lo = 32'h8000_0000;
                    e.hi = 32'h0;
                end else begin
                    e.lo = sa / sb;
                    e.hi = sa % sb;
                end
            end
            20: begin
                if (b == 32'h0) begin
                    e.lo = 32'hFFFF_FFFF;
                    e.hi = a;
                end else begin
                    e.lo = a / b;
                    e.hi = a % b;
                end
            end
            21: e.res = hi;
            22: e.res = lo;
            23: e.hi  = a;
            24: e.lo  = a;
            25: e.res = a;
            26: e.res = b;
            default: e.res = 32'h0;
        endcase
`ifndef ALU_OVERFLOW_EN
        e.ov = 1'b0;
`endif
        return e;
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Model snapshot at each edge, compared on the following falling edge.
    exp_t exp_q;
    bit   exp_vld = 1'b0;

    always @(posedge CLK) begin
        if (!RESET) exp_q = '0;
        else        exp_q = model(ALU_control, A, B, shiftAmount, HI_IN, LO_IN);
        exp_vld = 1'b1;
    end

    always @(negedge CLK) begin
        if (exp_vld) begin
            cmp("model_result", aluResult, exp_q.res);
            cmp("model_hi", HI_OUT, exp_q.hi);
            cmp("model_lo", LO_OUT, exp_q.lo);
            cmp("model_ovf", {31'h0, ov_act}, {31'h0, exp_q.ov});
        end
    end

    task automatic drive(input logic rst, input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, input logic [31:0] hi, input logic [31:0] lo);
        @(negedge CLK);
        RESET       = rst;
        ALU_control = op;
        A           = a;
        B           = b;
        shiftAmount = sh;
        HI_IN       = hi;
        LO_IN       = lo;
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h7FFF_FFFF;
            4:       return $urandom_range(0, 8);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        RESET       = 1'b0;
        A           = 32'd5;
        B           = 32'd7;
        ALU_control = 6'd0;
        shiftAmount = 5'd0;
        HI_IN       = 32'h0;
        LO_IN       = 32'h0;

        // Reset discards the ADD presented on the same edge.
        @(posedge CLK);
        #1;
        cmp("reset_result", aluResult, 32'h0);
        cmp("reset_hi", HI_OUT, 32'h0);
        cmp("reset_lo", LO_OUT, 32'h0);
        cmp("reset_ovf", {31'h0, ov_act}, 32'h0);

        drive(1'b1, 6'd0, 32'd5, 32'd7, 5'd0, 32'h0, 32'h0);
        cmp("add_after_reset", aluResult, 32'd12);

        drive(1'b1, 6'd0, 32'h7FFF_FFFF, 32'd1, 5'd0, 32'h0, 32'h0);
        cmp("add_wrap", aluResult, 32'h8000_0000);
`ifdef ALU_OVERFLOW_EN
        cmp("add_ovf", {31'h0, ov_act}, 32'd1);
`endif
        drive(1'b1, 6'd2, 32'd3, 32'd5, 5'd0, 32'h0, 32'h0);
        cmp("sub_neg", aluResult, 32'hFFFF_FFFE);
        drive(1'b1, 6'd8, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'h0, 32'h0);
        cmp("slt_signed", aluResult, 32'd1);
        drive(1'b1, 6'd9, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'h0, 32'h0);
        cmp("sltu_unsigned", aluResult, 32'd0);
        drive(1'b1, 6'd12, 32'h0, 32'h8000_0000, 5'd4, 32'h0, 32'h0);
        cmp("sra_4", aluResult, 32'hF800_0000);
        drive(1'b1, 6'd14, 32'd36, 32'h8000_0000, 5'd0, 32'h0, 32'h0);
        cmp("srlv_upper_ignored", aluResult, 32'h0800_0000);
        drive(1'b1, 6'd10, 32'h0, 32'hDEAD_BEEF, 5'd0, 32'h0, 32'h0);
        cmp("sll_zero_amount", aluResult, 32'hDEAD_BEEF);
        drive(1'b1, 6'd16, 32'h0, 32'h1234, 5'd0, 32'h0, 32'h0);
        cmp("lui", aluResult, 32'h1234_0000);
        drive(1'b1, 6'd17, 32'hFFFF_FFFE, 32'd3, 5'd0, 32'h0, 32'h0);
        cmp("mult_hi", HI_OUT, 32'hFFFF_FFFF);
        cmp("mult_lo", LO_OUT, 32'hFFFF_FFFA);
        cmp("mult_result", aluResult, 32'h0);
        drive(1'b1, 6'd18, 32'hFFFF_FFFE, 32'd3, 5'd0, 32'h0, 32'h0);
        cmp("multu_hi", HI_OUT, 32'd2);
        cmp("multu_lo", LO_OUT, 32'hFFFF_FFFA);
        drive(1'b1, 6'd19, 32'hFFFF_FFF9, 32'd2, 5'd0, 32'h0, 32'h0);
        cmp("div_lo", LO_OUT, 32'hFFFF_FFFD);
        cmp("div_hi", HI_OUT, 32'hFFFF_FFFF);
        drive(1'b1, 6'd20, 32'd9, 32'd0, 5'd0, 32'h0, 32'h0);
        cmp("divu_zero_lo", LO_OUT, 32'hFFFF_FFFF);
        cmp("divu_zero_hi", HI_OUT, 32'd9);
        drive(1'b1, 6'd19, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 32'h0, 32'h0);
        cmp("div_ovf_lo", LO_OUT, 32'h8000_0000);
        cmp("div_ovf_hi", HI_OUT, 32'h0);
        drive(1'b1, 6'd4, 32'h1, 32'h2, 5'd0, 32'hAA, 32'hBB);
        cmp("and_hi_pass", HI_OUT, 32'hAA);
        cmp("and_lo_pass", LO_OUT, 32'hBB);
        drive(1'b1, 6'd21, 32'h1, 32'h2, 5'd0, 32'hAA, 32'hBB);
        cmp("mfhi", aluResult, 32'hAA);
        drive(1'b1, 6'd24, 32'h55, 32'h2, 5'd0, 32'hAA, 32'hBB);
        cmp("mtlo_lo", LO_OUT, 32'h55);
        cmp("mtlo_hi", HI_OUT, 32'hAA);
        cmp("mtlo_result", aluResult, 32'h0);
        drive(1'b1, 6'd40, 32'h1234, 32'h5678, 5'd0, 32'hAA, 32'hBB);
        cmp("op40_zero", aluResult, 32'h0);

        // Randomized traffic, mostly defined opcodes, with occasional reset pulses.
        for (int i = 0; i < 3000; i++) begin
            @(negedge CLK);
            RESET       = ($urandom_range(0, 49) != 0);
            ALU_control = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(27, 63))
                                                      : 6'($urandom_range(0, 26));
            A           = rand_word();
            B           = rand_word();
            shiftAmount = 5'($urandom_range(0, 31));
            HI_IN       = $urandom;
            LO_IN       = $urandom;
        end
        @(negedge CLK);
        @(negedge CLK);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
